// File: rtl/zcmt_dcache_arbiter.sv
// Shares one D$ load port between the load unit and Zcmt table fetch.
// Ports: ld_*/zc_* requester sides, dc_* cache side, busy_o/timeout_o status.
module zcmt_dcache_arbiter #(
  parameter int ADDR_WIDTH     = 34,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  ld_req_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [1:0]            ld_size_i,
  input  logic [ID_WIDTH-1:0]   ld_id_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic                  ld_err_o,
  input  logic                  zc_req_i,
  input  logic [ADDR_WIDTH-1:0] zc_addr_i,
  input  logic [1:0]            zc_size_i,
  input  logic [ID_WIDTH-1:0]   zc_id_i,
  output logic                  zc_gnt_o,
  output logic                  zc_rvalid_o,
  output logic [DATA_WIDTH-1:0] zc_rdata_o,
  output logic                  zc_err_o,
  output logic                  dc_req_o,
  output logic [ADDR_WIDTH-1:0] dc_addr_o,
  output logic [1:0]            dc_size_o,
  output logic [ID_WIDTH-1:0]   dc_id_o,
  output logic                  dc_kill_o,
  input  logic                  dc_gnt_i,
  input  logic                  dc_rvalid_i,
  input  logic [ID_WIDTH-1:0]   dc_rid_i,
  input  logic [DATA_WIDTH-1:0] dc_rdata_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  // Owner encoding: 0 = LD, 1 = ZC.
  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  own_q, own_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  gnt, rv, err, kill, tmo;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  pick_zc, hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    addr_d  = addr_q;
    size_d  = size_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    rv      = 1'b0;
    err     = 1'b0;
    kill    = 1'b0;
    tmo     = 1'b0;
    rdata   = '0;
    // Tie goes to whoever did not complete last.
    pick_zc = zc_req_i & (~ld_req_i | ~last_q);
    hit     = dc_rvalid_i & (dc_rid_i == id_q);
    unique case (state_q)
      S_IDLE: begin
        if (!flush_i && (ld_req_i || zc_req_i)) begin
          own_d   = pick_zc;
          addr_d  = pick_zc ? zc_addr_i : ld_addr_i;
          size_d  = pick_zc ? zc_size_i : ld_size_i;
          id_d    = pick_zc ? zc_id_i : ld_id_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dc_gnt_i) begin
          if (flush_i) begin
            // Cache already took it; it must be cancelled.
            kill    = 1'b1;
            state_d = S_IDLE;
          end else begin
            gnt     = 1'b1;
            cnt_d   = '0;
            state_d = S_RESP;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (flush_i) begin
          kill    = 1'b1;
          state_d = S_IDLE;
        end else if (hit) begin
          rv      = 1'b1;
          rdata   = dc_rdata_i;
          last_d  = own_q;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          kill    = 1'b1;
          rv      = 1'b1;
          err     = 1'b1;
          last_d  = own_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset drops the transaction without any pulse.
    if (rst_i) begin
      gnt   = 1'b0;
      rv    = 1'b0;
      err   = 1'b0;
      kill  = 1'b0;
      tmo   = 1'b0;
      rdata = '0;
    end
  end

  assign ld_gnt_o    = gnt & ~own_q;
  assign zc_gnt_o    = gnt & own_q;
  assign ld_rvalid_o = rv & ~own_q;
  assign zc_rvalid_o = rv & own_q;
  assign ld_err_o    = err & ~own_q;
  assign zc_err_o    = err & own_q;
  assign ld_rdata_o  = ld_rvalid_o ? rdata : '0;
  assign zc_rdata_o  = zc_rvalid_o ? rdata : '0;

  assign dc_req_o  = (state_q == S_REQ);
  assign dc_addr_o = addr_q;
  assign dc_size_o = size_q;
  assign dc_id_o   = id_q;
  assign dc_kill_o = kill;
  assign busy_o    = (state_q != S_IDLE);
  assign timeout_o = tmo;

endmodule

// File: tb/tb_zcmt_dcache_arbiter.sv
// Bench for zcmt_dcache_arbiter: per-cycle transaction model plus
// directed scenarios with literal expectations.
module tb_zcmt_dcache_arbiter;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int TO = 8;

  logic clk = 0;
  logic rst_i = 1;
  logic flush_i = 0;
  logic ld_req_i = 0, zc_req_i = 0;
  logic [AW-1:0] ld_addr_i = 0, zc_addr_i = 0;
  logic [1:0] ld_size_i = 0, zc_size_i = 0;
  logic [IW-1:0] ld_id_i = 0, zc_id_i = 0;
  logic ld_gnt_o, zc_gnt_o, ld_rvalid_o, zc_rvalid_o;
  logic [DW-1:0] ld_rdata_o, zc_rdata_o;
  logic ld_err_o, zc_err_o;
  logic dc_req_o, dc_kill_o, busy_o, timeout_o;
  logic [AW-1:0] dc_addr_o;
  logic [1:0] dc_size_o;
  logic [IW-1:0] dc_id_o;
  logic dc_gnt_i = 0, dc_rvalid_i = 0;
  logic [IW-1:0] dc_rid_i = 0;
  logic [DW-1:0] dc_rdata_i = 0;

  int checks = 0;
  int errors = 0;
  bit glog[$];

  zcmt_dcache_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i),
    .ld_size_i(ld_size_i), .ld_id_i(ld_id_i),
    .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o),
    .ld_rdata_o(ld_rdata_o), .ld_err_o(ld_err_o),
    .zc_req_i(zc_req_i), .zc_addr_i(zc_addr_i),
    .zc_size_i(zc_size_i), .zc_id_i(zc_id_i),
    .zc_gnt_o(zc_gnt_o), .zc_rvalid_o(zc_rvalid_o),
    .zc_rdata_o(zc_rdata_o), .zc_err_o(zc_err_o),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o),
    .dc_size_o(dc_size_o), .dc_id_o(dc_id_o),
    .dc_kill_o(dc_kill_o), .dc_gnt_i(dc_gnt_i),
    .dc_rvalid_i(dc_rvalid_i), .dc_rid_i(dc_rid_i),
    .dc_rdata_i(dc_rdata_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 none, 1 waiting accept,
  // 2 waiting data. who: 0 LD, 1 ZC.
  int m_ph = 0;
  int m_wait = 0;
  bit m_who = 0;
  bit m_prev = 1;
  logic [AW-1:0] m_addr = 0;
  logic [1:0] m_size = 0;
  logic [IW-1:0] m_id = 0;

  always @(negedge clk) begin
    logic e_lg, e_zg, e_lv, e_zv, e_le, e_ze;
    logic e_kill, e_to;
    logic [DW-1:0] e_lr, e_zr;
    int nph;
    bit w;
    bit done;
    bit bad;
    logic [DW-1:0] dd;
    e_lg = 0; e_zg = 0; e_lv = 0; e_zv = 0;
    e_le = 0; e_ze = 0; e_kill = 0; e_to = 0;
    e_lr = 0; e_zr = 0; done = 0; bad = 0; dd = 0;
    nph = m_ph;
    if (ld_gnt_o) glog.push_back(1'b0);
    if (zc_gnt_o) glog.push_back(1'b1);
    if (rst_i) begin
      chk("rst_kill", dc_kill_o, 0);
      chk("rst_gnt", {ld_gnt_o, zc_gnt_o}, 0);
      chk("rst_rv", {ld_rvalid_o, zc_rvalid_o}, 0);
      chk("rst_to", timeout_o, 0);
      m_ph = 0; m_wait = 0; m_who = 0; m_prev = 1;
      m_addr = 0; m_size = 0; m_id = 0;
    end else begin
      chk("m_busy", busy_o, 64'(m_ph != 0));
      chk("m_req", dc_req_o, 64'(m_ph == 1));
      chk("m_addr", dc_addr_o, m_addr);
      chk("m_size", dc_size_o, m_size);
      chk("m_id", dc_id_o, m_id);
      if (m_ph == 0) begin
        if (!flush_i && (ld_req_i || zc_req_i)) begin
          if (ld_req_i && zc_req_i) w = ~m_prev;
          else w = zc_req_i;
          m_who = w;
          m_addr = w ? zc_addr_i : ld_addr_i;
          m_size = w ? zc_size_i : ld_size_i;
          m_id = w ? zc_id_i : ld_id_i;
          nph = 1;
        end
      end else if (m_ph == 1) begin
        if (dc_gnt_i && flush_i) begin
          e_kill = 1; nph = 0;
        end else if (dc_gnt_i) begin
          if (m_who) e_zg = 1; else e_lg = 1;
          m_wait = 0; nph = 2;
        end else if (flush_i) nph = 0;
      end else begin
        if (flush_i) begin
          e_kill = 1; nph = 0;
        end else if (dc_rvalid_i && dc_rid_i == m_id) begin
          done = 1; dd = dc_rdata_i;
        end else if (m_wait == TO - 1) begin
          done = 1; bad = 1;
          e_to = 1; e_kill = 1;
        end else m_wait++;
        if (done) begin
          if (m_who) begin
            e_zv = 1; e_zr = dd; e_ze = bad;
          end else begin
            e_lv = 1; e_lr = dd; e_le = bad;
          end
          m_prev = m_who; nph = 0;
        end
      end
      chk("m_ld_gnt", ld_gnt_o, e_lg);
      chk("m_zc_gnt", zc_gnt_o, e_zg);
      chk("m_ld_rv", ld_rvalid_o, e_lv);
      chk("m_zc_rv", zc_rvalid_o, e_zv);
      chk("m_ld_rd", ld_rdata_o, e_lr);
      chk("m_zc_rd", zc_rdata_o, e_zr);
      chk("m_ld_err", ld_err_o, e_le);
      chk("m_zc_err", zc_err_o, e_ze);
      chk("m_kill", dc_kill_o, e_kill);
      chk("m_to", timeout_o, e_to);
      m_ph = nph;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush_i = 0; ld_req_i = 0; zc_req_i = 0;
    dc_gnt_i = 0; dc_rvalid_i = 0;
    dc_rid_i = 0; dc_rdata_i = 0;
  endtask

  task automatic do_reset();
    clr();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
  endtask

  initial begin
    bit pat[4];
    pat = '{1'b0, 1'b1, 1'b0, 1'b1};
    // Basic LD transaction with literal timing.
    do_reset();
    ld_req_i = 1; ld_addr_i = 34'h100;
    ld_id_i = 1; ld_size_i = 2;
    #1 chk("t1_req_c0", dc_req_o, 0);
    tick();
    #1 chk("t1_req_c1", dc_req_o, 1);
    chk("t1_addr", dc_addr_o, 34'h100);
    tick();
    tick(); dc_gnt_i = 1;
    #1 chk("t1_gnt_c3", ld_gnt_o, 1);
    tick(); clr();
    #1 chk("t1_busy_c4", busy_o, 1);
    tick();
    dc_rvalid_i = 1; dc_rid_i = 1;
    dc_rdata_i = 32'hDEADBEEF;
    #1 chk("t1_rv_c5", ld_rvalid_o, 1);
    chk("t1_rd_c5", ld_rdata_o, 32'hDEADBEEF);
    chk("t1_zc_rv", zc_rvalid_o, 0);
    chk("t1_zc_rd", zc_rdata_o, 0);
    tick(); clr();
    #1 chk("t1_idle", busy_o, 0);

    // Round robin with both held and an eager cache.
    do_reset();
    glog.delete();
    ld_req_i = 1; zc_req_i = 1;
    ld_id_i = 1; zc_id_i = 1;
    ld_addr_i = 34'h200; zc_addr_i = 34'h300;
    dc_gnt_i = 1; dc_rvalid_i = 1;
    dc_rid_i = 1; dc_rdata_i = 32'h55;
    repeat (12) tick();
    clr();
    tick();
    chk("t2_ngrants", glog.size(), 4);
    for (int i = 0; i < glog.size() && i < 4; i++)
      chk($sformatf("t2_pat%0d", i), glog[i], pat[i]);
    for (int i = 1; i < glog.size(); i++)
      chk("t2_alt", 64'(glog[i] != glog[i-1]), 1);

    // Non-matching ID is ignored.
    do_reset();
    zc_req_i = 1; zc_id_i = 3; zc_addr_i = 34'h400;
    tick(); dc_gnt_i = 1;
    #1 chk("t3_gnt", zc_gnt_o, 1);
    tick(); clr();
    dc_rvalid_i = 1; dc_rid_i = 2; dc_rdata_i = 32'h1111;
    #1 chk("t3_rid2_rv", zc_rvalid_o, 0);
    chk("t3_rid2_rd", zc_rdata_o, 0);
    tick();
    dc_rvalid_i = 1; dc_rid_i = 3; dc_rdata_i = 32'h2222;
    #1 chk("t3_rid3_rv", zc_rvalid_o, 1);
    chk("t3_rid3_rd", zc_rdata_o, 32'h2222);
    tick(); clr();

    // Watchdog on a ZC fetch.
    zc_req_i = 1; zc_id_i = 0; zc_addr_i = 34'h500;
    tick(); dc_gnt_i = 1;
    tick(); clr();
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) tick();
      #1;
      if (k < TO) chk("t4_no_to", timeout_o, 0);
    end
    chk("t4_to", timeout_o, 1);
    chk("t4_kill", dc_kill_o, 1);
    chk("t4_rv", zc_rvalid_o, 1);
    chk("t4_err", zc_err_o, 1);
    chk("t4_rd", zc_rdata_o, 0);
    tick();
    #1 chk("t4_idle", busy_o, 0);

    // Flush in REQ without accept.
    ld_req_i = 1; ld_id_i = 2;
    tick(); flush_i = 1;
    #1 chk("t5a_kill", dc_kill_o, 0);
    chk("t5a_gnt", ld_gnt_o, 0);
    tick(); clr();
    #1 chk("t5a_idle", busy_o, 0);
    // Flush together with accept.
    ld_req_i = 1;
    tick(); flush_i = 1; dc_gnt_i = 1;
    #1 chk("t5b_kill", dc_kill_o, 1);
    chk("t5b_gnt", ld_gnt_o, 0);
    tick(); clr();
    #1 chk("t5b_idle", busy_o, 0);
    // Flush in RESP beats a matching response.
    ld_req_i = 1;
    tick(); dc_gnt_i = 1;
    tick(); clr();
    flush_i = 1; dc_rvalid_i = 1;
    dc_rid_i = 2; dc_rdata_i = 32'h3333;
    #1 chk("t5c_kill", dc_kill_o, 1);
    chk("t5c_rv", ld_rvalid_o, 0);
    chk("t5c_rd", ld_rdata_o, 0);
    tick(); clr();
    #1 chk("t5c_idle", busy_o, 0);

    // Reset in RESP after LD completed last.
    ld_req_i = 1; ld_id_i = 1;
    tick(); dc_gnt_i = 1;
    tick(); clr();
    dc_rvalid_i = 1; dc_rid_i = 1;
    tick(); clr();
    zc_req_i = 1; zc_id_i = 1;
    tick(); dc_gnt_i = 1;
    tick(); clr();
    rst_i = 1;
    #1 chk("t6_rst_kill", dc_kill_o, 0);
    tick(); rst_i = 0;
    #1 chk("t6_busy", busy_o, 0);
    chk("t6_req", dc_req_o, 0);
    chk("t6_addr", dc_addr_o, 0);
    ld_req_i = 1; zc_req_i = 1;
    ld_addr_i = 34'h600; zc_addr_i = 34'h700;
    tick(); dc_gnt_i = 1;
    #1 chk("t6_addr_ld", dc_addr_o, 34'h600);
    chk("t6_ld_gnt", ld_gnt_o, 1);
    chk("t6_zc_gnt", zc_gnt_o, 0);
    tick(); clr();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
